regwb_writer: RTL
=================

# regwb_writer

Write-back writer for the 8-entry × 8-bit register file. It collects results from the ALU and the load path, queues them in a small in-order FIFO, and drives the register file's write port (`regwrite`/`writereg`/`writedata`) with one write per cycle. It also gives the operand-fetch logic a forwarding lookup over every write still pending, so reads never see a stale value.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; must be a power of two and ≥ 2.
- `DW`, default 8: data width.
- `AW`, default 3: register address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_reg`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `mem_valid`  in  1  load result present this cycle.
- `mem_reg`  in  AW  load destination register.
- `mem_data`  in  DW  load result.
- `stall`  out  1  combinational; when 1, no offered result is accepted this cycle.
- `regwrite`  out  1  registered write enable to the register file.
- `writereg`  out  AW  registered write address.
- `writedata`  out  DW  registered write data.
- `lookup1_reg`, `lookup2_reg`  in  AW  operand addresses, wired in parallel with the register file's `readreg1`/`readreg2`.
- `hit1`, `hit2`  out  1  combinational; a pending write targets the looked-up register.
- `fwd1_data`, `fwd2_data`  out  DW  combinational; value from the youngest pending write to that register, or 0 when there is no hit.

## Operation
- `nvalid` = `alu_valid` + `mem_valid` (0..2).
- `count` is the FIFO occupancy, 0..DEPTH, with width $clog2(DEPTH)+1.
- Stall rule:
  - `stall` = (`count` > DEPTH − `nvalid`).
  - The rule does not credit the pop in the same cycle.
  - Acceptance is all-or-nothing: when stalled, neither result is enqueued. Producers hold their inputs until `stall` = 0.
- Enqueue order on simultaneous valids: `mem` result first (older), then `alu`. Two entries are written in one edge.
- Drain: on every edge where `count` ≠ 0, the head entry is popped into the output register and `regwrite` ← 1.
  - With `count` = 0, `regwrite` ← 0.
  - `writereg`/`writedata` hold their previous values.
- Simultaneous pop and enqueue in one edge: `count` ← `count` − 1 + `nvalid`.
- Pointers wrap modulo DEPTH.
- Writes to register 0 are ordinary writes; there is no hard-wired zero register.
- Duplicate destinations in flight are legal. The register file receives them in order, so the last accepted value wins.
- Forwarding lookup:
  - Search set: all valid FIFO entries plus the output register when `regwrite` = 1.
  - Priority, youngest first: FIFO tail−1 … head, then the output register.
  - Accepted inputs of the current cycle are not searched.
- Reset at any time: FIFO emptied, pointers and `count` ← 0. Pending writes are discarded, not flushed.

## Timing
- Reset values: `regwrite` = 0, `writereg` = 0, `writedata` = 0, `stall` = 0, `hit1` = `hit2` = 0, `fwd1_data` = `fwd2_data` = 0.
- Latency into an empty queue: a result accepted at edge N is popped at edge N+1, so `regwrite` = 1 between edges N+1 and N+2.
- Throughput: one register write per cycle. With two results accepted every cycle, the queue fills and `stall` throttles the producers.
- `stall`, `hit*`, `fwd*` are purely combinational from state and current inputs. There is no combinational path from `*_valid` to `regwrite`.

## Structure
- Shared package `regwb_pkg` holds:
  - `DW`, `AW`, `DEPTH` defaults.
  - Entry typedef `wb_entry_t` = {`reg` [AW-1:0], `data` [DW-1:0]}.
- Sub-module `regwb_fifo`: DEPTH-entry storage with two write ports and one read port. It keeps the head/tail pointers and `count`, and exposes the per-entry valid and contents to the lookup logic.
- The top level contains the stall rule, the enqueue ordering, the output register and two identical priority-search instances, one per lookup port.

## Test plan
- Single write: reset, then `alu_valid` = 1, `alu_reg` = 5, `alu_data` = 0x3C for one cycle → `regwrite` = 1, `writereg` = 5, `writedata` = 0x3C in the cycle after the next edge, then `regwrite` = 0.
- Simultaneous results: `mem` (r2, 0x11) and `alu` (r3, 0x22) in the same cycle → two consecutive writes, r2/0x11 then r3/0x22.
- Full queue: 3 cycles of dual valids with DEPTH = 4 → `stall` = 1 once `count` > 2. No entry is lost or duplicated, and the drain order matches acceptance order.
- Forwarding: queue r4 = 0x0A then r4 = 0x0B, with `lookup1_reg` = 4 → `hit1` = 1, `fwd1_data` = 0x0B. After both writes drain, `hit1` = 0 and `fwd1_data` = 0.
- Reset mid-operation: 3 entries pending, assert `reset` asynchronously between edges → `regwrite`, `count` and `hit*` go to 0 immediately, and no further writes occur after release.

Source files
------------

// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared defaults and entry type for the register write-back writer
package regwb_pkg;
   localparam int DEF_DW    = 8;
   localparam int DEF_AW    = 3;
   localparam int DEF_DEPTH = 4;

   typedef struct packed {
      logic [DEF_AW-1:0] dst;
      logic [DEF_DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// rtl/regwb_fifo.sv - in-order write-back queue, two write ports, one read port, age-ordered view
module regwb_fifo
   import regwb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int EW    = DEF_AW + DEF_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr0_en,
   input  logic [EW-1:0]       wr0_data,
   input  logic                wr1_en,
   input  logic [EW-1:0]       wr1_data,
   input  logic                rd_en,
   output logic [EW-1:0]       rd_data,
   output logic [CW-1:0]       count,
   output logic [DEPTH-1:0]    age_valid,
   output logic [DEPTH*EW-1:0] age_data
);
   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      tail_p1 = tail_q + PW'(1);
      head_d  = head_q + PW'(rd_en);
      tail_d  = tail_q + PW'(wr0_en) + PW'(wr1_en);
      count_d = count_q - CW'(rd_en) + CW'(wr0_en) + CW'(wr1_en);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is not cleared on reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[tail_q]  <= wr0_data;
      if (wr1_en) mem_q[tail_p1] <= wr1_data;
   end

   assign rd_data = mem_q[head_q];
   assign count   = count_q;

   // Slot g of the age view is the g-th oldest pending entry.
   for (genvar g = 0; g < DEPTH; g++) begin : g_age
      logic [PW-1:0] idx;
      assign idx                  = head_q + PW'(g);
      assign age_data[g*EW +: EW] = mem_q[idx];
      assign age_valid[g]         = (CW'(g) < count_q);
   end
endmodule

// File: rtl/regwb_lookup.sv
// rtl/regwb_lookup.sv - youngest-first search of pending writes for one operand port
module regwb_lookup
   import regwb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   localparam int EW   = AW + DW
) (
   input  logic [AW-1:0]       lookup_reg,
   input  logic [DEPTH-1:0]    age_valid,
   input  logic [DEPTH*EW-1:0] age_data,
   input  logic                out_valid,
   input  logic [AW-1:0]       out_reg,
   input  logic [DW-1:0]       out_data,
   output logic                hit,
   output logic [DW-1:0]       fwd_data
);
   // Oldest candidate first so that each younger match overrides it.
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      if (out_valid && out_reg == lookup_reg) begin
         hit      = 1'b1;
         fwd_data = out_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && age_data[i*EW+DW +: AW] == lookup_reg) begin
            hit      = 1'b1;
            fwd_data = age_data[i*EW +: DW];
         end
      end
   end
endmodule

// File: rtl/regwb_writer.sv
// rtl/regwb_writer.sv - queues ALU/load results and drives the register-file write port
module regwb_writer
   import regwb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   localparam int EW   = AW + DW,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_reg,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   input  logic [AW-1:0] mem_reg,
   input  logic [DW-1:0] mem_data,
   output logic          stall,
   output logic          regwrite,
   output logic [AW-1:0] writereg,
   output logic [DW-1:0] writedata,
   input  logic [AW-1:0] lookup1_reg,
   input  logic [AW-1:0] lookup2_reg,
   output logic          hit1,
   output logic          hit2,
   output logic [DW-1:0] fwd1_data,
   output logic [DW-1:0] fwd2_data
);
   logic [1:0]          nvalid;
   logic                accept, wr1_en, rd_en;
   logic [EW-1:0]       wr0_data, wr1_data, rd_data;
   logic [CW-1:0]       count;
   logic [DEPTH-1:0]    age_valid;
   logic [DEPTH*EW-1:0] age_data;

   logic          regwrite_q, regwrite_d;
   logic [AW-1:0] writereg_q, writereg_d;
   logic [DW-1:0] writedata_q, writedata_d;

   // The same-cycle pop is deliberately not credited, keeping stall off the drain path.
   assign nvalid = {1'b0, alu_valid} + {1'b0, mem_valid};
   assign stall  = (32'(count) + 32'(nvalid)) > 32'(DEPTH);
   assign accept = !stall && (alu_valid || mem_valid);

   // Load result is older, so it takes the first slot when both arrive.
   assign wr0_data = mem_valid ? {mem_reg, mem_data} : {alu_reg, alu_data};
   assign wr1_data = {alu_reg, alu_data};
   assign wr1_en   = accept && alu_valid && mem_valid;
   assign rd_en    = (count != '0);

   regwb_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr0_en   (accept),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_data (wr1_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .count    (count),
      .age_valid(age_valid),
      .age_data (age_data)
   );

   always_comb begin
      regwrite_d  = rd_en;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      if (rd_en) begin
         writereg_d  = rd_data[EW-1 -: AW];
         writedata_d = rd_data[DW-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
      end
   end

   assign regwrite  = regwrite_q;
   assign writereg  = writereg_q;
   assign writedata = writedata_q;

   regwb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lookup1 (
      .lookup_reg(lookup1_reg),
      .age_valid (age_valid),
      .age_data  (age_data),
      .out_valid (regwrite_q),
      .out_reg   (writereg_q),
      .out_data  (writedata_q),
      .hit       (hit1),
      .fwd_data  (fwd1_data)
   );

   regwb_lookup #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_lookup2 (
      .lookup_reg(lookup2_reg),
      .age_valid (age_valid),
      .age_data  (age_data),
      .out_valid (regwrite_q),
      .out_reg   (writereg_q),
      .out_data  (writedata_q),
      .hit       (hit2),
      .fwd_data  (fwd2_data)
   );
endmodule
